// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate extender and its inverse, imm_encode.
//   imm_src_t      : ImmSrc encoding, common to extender and encoder.
//   enc_state_t    : state encoding of the encoder's control FSM.
//   ROT_CANDIDATES : number of rotation amounts in the rotated-imm8 form.
// -----------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [1:0] {
        IMM8   = 2'b00,   // imm8 zero-extended
        IMM12  = 2'b01,   // imm12 zero-extended
        BRANCH = 2'b10,   // signed word offset, 24-bit field
        ROT8   = 2'b11    // imm8 rotated right by 2*rot
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        DONE   = 2'b10
    } enc_state_t;

    localparam int ROT_CANDIDATES = 16;

endpackage

// File: rtl/imm_encode_rot_check.sv
// -----------------------------------------------------------------------------
// rot_check
// Combinational test of one rotation candidate for the rotated-imm8 form.
// Rotates value left by 2*rot; the candidate hits when the result fits in
// the low 8 bits, in which case ror(imm8, 2*rot) reproduces value.
//   value : constant being encoded
//   rot   : rotation field candidate (0..15)
//   hit   : candidate represents value
//   imm8  : low byte of the rotated value (the imm8 field on a hit)
// -----------------------------------------------------------------------------
module rot_check (
    input  logic [31:0] value,
    input  logic [3:0]  rot,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [5:0]  shamt;
    logic [31:0] rotated;

    always_comb begin
        shamt   = {1'b0, rot, 1'b0};
        // For shamt==0 the right shift is by 32 and contributes nothing.
        rotated = (value << shamt) | (value >> (6'd32 - shamt));
        hit     = (rotated[31:8] == 24'd0);
        imm8    = rotated[7:0];
    end

endmodule

// File: rtl/imm_encode.sv
// -----------------------------------------------------------------------------
// imm_encode
// Inverse of the datapath immediate extender: turns a 32-bit constant and an
// ImmSrc code into the 24-bit instruction field that extends back to it.
// Modes 00/01/10 resolve in the accept cycle; mode 11 walks the 16 rotation
// amounts, ROTS_PER_CYCLE per cycle, and reports the smallest one that fits.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : request handshake (accepted only in IDLE)
//   ImmVal, ImmSrc      : constant and requested encoding
//   out_valid, out_ready: result handshake (result held until accepted)
//   InstrField, Fail    : encoded field (zero on Fail), not-representable flag
// -----------------------------------------------------------------------------
module imm_encode
    import imm_pkg::*;
#(
    parameter int ROTS_PER_CYCLE = 1   // 1, 2, 4, 8 or 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ImmVal,
    input  logic [1:0]  ImmSrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] InstrField,
    output logic        Fail
);

    enc_state_t  state_q, state_d;
    logic [31:0] val_q, val_d;
    logic [3:0]  rot_q, rot_d;
    logic [23:0] field_q, field_d;
    logic        fail_q, fail_d;

    // Direct encoding for the three non-iterative modes.
    logic        direct_fail;
    logic [23:0] direct_field;

    always_comb begin
        direct_fail  = 1'b1;
        direct_field = 24'd0;
        case (imm_src_t'(ImmSrc))
            IMM8: begin
                direct_fail  = (ImmVal[31:8] != 24'd0);
                direct_field = {16'd0, ImmVal[7:0]};
            end
            IMM12: begin
                direct_fail  = (ImmVal[31:12] != 20'd0);
                direct_field = {12'd0, ImmVal[11:0]};
            end
            BRANCH: begin
                // Word aligned, and bits 31:25 a pure sign extension of bit 25.
                direct_fail  = (ImmVal[1:0] != 2'b00) ||
                               !((ImmVal[31:25] == 7'h00) || (ImmVal[31:25] == 7'h7F));
                direct_field = ImmVal[25:2];
            end
            default: begin
                direct_fail  = 1'b1;
                direct_field = 24'd0;
            end
        endcase
    end

    // Rotation search datapath: candidates rot_q .. rot_q+ROTS_PER_CYCLE-1.
    logic [ROTS_PER_CYCLE-1:0] hit_vec;
    logic [7:0]                imm8_vec [ROTS_PER_CYCLE];
    logic [3:0]                cand_rot [ROTS_PER_CYCLE];

    for (genvar g = 0; g < ROTS_PER_CYCLE; g++) begin : g_rot
        assign cand_rot[g] = rot_q + 4'(g);
        rot_check u_rot_check (
            .value (val_q),
            .rot   (cand_rot[g]),
            .hit   (hit_vec[g]),
            .imm8  (imm8_vec[g])
        );
    end

    logic       hit_any;
    logic [3:0] hit_rot;
    logic [7:0] hit_imm8;
    logic       last_chunk;

    always_comb begin
        hit_any  = 1'b0;
        hit_rot  = 4'd0;
        hit_imm8 = 8'd0;
        // Scan downward so the lowest hitting candidate is the one kept.
        for (int i = ROTS_PER_CYCLE - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any  = 1'b1;
                hit_rot  = cand_rot[i];
                hit_imm8 = imm8_vec[i];
            end
        end
        last_chunk = (({1'b0, rot_q} + 5'(ROTS_PER_CYCLE)) == 5'(ROT_CANDIDATES));
    end

    // Control FSM next state and result capture.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rot_d   = rot_q;
        field_d = field_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d = ImmVal;
                    if (imm_src_t'(ImmSrc) == ROT8) begin
                        rot_d   = 4'd0;
                        state_d = SEARCH;
                    end else begin
                        field_d = direct_fail ? 24'd0 : direct_field;
                        fail_d  = direct_fail;
                        state_d = DONE;
                    end
                end
            end
            SEARCH: begin
                if (hit_any) begin
                    field_d = {12'd0, hit_rot, hit_imm8};
                    fail_d  = 1'b0;
                    state_d = DONE;
                end else if (last_chunk) begin
                    field_d = 24'd0;
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rot_d = rot_q + 4'(ROTS_PER_CYCLE);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            field_q <= 24'd0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            fail_q  <= fail_d;
        end
    end

    // Search operands carry no meaning outside SEARCH and are loaded on entry.
    always_ff @(posedge clk) begin
        val_q <= val_d;
        rot_q <= rot_d;
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign InstrField = field_q;
    assign Fail       = fail_q;

endmodule

// File: tb/tb_imm_encode.sv
// -----------------------------------------------------------------------------
// tb_imm_encode
// Self-checking bench for imm_encode (ROTS_PER_CYCLE=1): directed vector
// table, backpressure and reset-in-search sequences, and a randomized sweep
// against an independent model of the immediate extender.
// -----------------------------------------------------------------------------
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ImmVal;
    logic [1:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] InstrField;
    logic        Fail;

    always #5 clk = ~clk;

    imm_encode #(.ROTS_PER_CYCLE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ImmVal     (ImmVal),
        .ImmSrc     (ImmSrc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .InstrField (InstrField),
        .Fail       (Fail)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned s);
        if (s == 0) return v;
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] v, input int unsigned s);
        if (s == 0) return v;
        return (v >> s) | (v << (32 - s));
    endfunction

    // Model of the datapath extender for modes 00/01/10.
    function automatic logic [31:0] extend(input logic [23:0] f, input logic [1:0] src);
        case (src)
            2'b00:   return {24'd0, f[7:0]};
            2'b01:   return {20'd0, f[11:0]};
            2'b10:   return {{6{f[23]}}, f, 2'b00};
            default: return 32'd0;
        endcase
    endfunction

    // Issue one request from IDLE (called #1 after a rising edge), measure
    // latency in cycles from the handshake edge, then accept the result.
    task automatic send(input logic [1:0] src, input logic [31:0] val,
                        output int lat, output logic [23:0] fld, output logic fl);
        ImmSrc   = src;
        ImmVal   = val;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
        fld = InstrField;
        fl  = Fail;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [31:0] val;
        logic [23:0] field;
        logic        fail;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        int          lat;
        logic [23:0] fld;
        logic        fl;

        vecs[0]  = '{2'b00, 32'h0000_00A5, 24'h0000A5, 1'b0, 1};
        vecs[1]  = '{2'b00, 32'h0000_0100, 24'h000000, 1'b1, 1};
        vecs[2]  = '{2'b01, 32'h0000_1000, 24'h000000, 1'b1, 1};
        vecs[3]  = '{2'b01, 32'h0000_0FFF, 24'h000FFF, 1'b0, 1};
        vecs[4]  = '{2'b01, 32'h0000_0ABC, 24'h000ABC, 1'b0, 1};
        vecs[5]  = '{2'b10, 32'hFFFF_FFF8, 24'hFFFFFE, 1'b0, 1};
        vecs[6]  = '{2'b10, 32'h0000_0006, 24'h000000, 1'b1, 1};
        vecs[7]  = '{2'b10, 32'h0400_0000, 24'h000000, 1'b1, 1};
        vecs[8]  = '{2'b10, 32'h01FF_FFFC, 24'h7FFFFF, 1'b0, 1};
        vecs[9]  = '{2'b10, 32'hFE00_0000, 24'h800000, 1'b0, 1};
        vecs[10] = '{2'b11, 32'hFF00_0000, 24'h0004FF, 1'b0, 6};
        vecs[11] = '{2'b11, 32'h0000_0000, 24'h000000, 1'b0, 2};
        vecs[12] = '{2'b11, 32'h0000_0102, 24'h000000, 1'b1, 17};
        vecs[13] = '{2'b11, 32'h0000_00AB, 24'h0000AB, 1'b0, 2};
        vecs[14] = '{2'b11, 32'h0000_03FC, 24'h000FFF, 1'b0, 17};
        vecs[15] = '{2'b11, 32'hC000_003F, 24'h0001FF, 1'b0, 3};
        vecs[16] = '{2'b11, 32'hFFFF_FFFF, 24'h000000, 1'b1, 17};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ImmVal    = 32'd0;
        ImmSrc    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_field",     32'(InstrField), 32'd0);
        chk("rst_fail",      32'(Fail),       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            send(vecs[i].src, vecs[i].val, lat, fld, fl);
            chk($sformatf("v%0d_lat", i),   32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_field", i), 32'(fld), 32'(vecs[i].field));
            chk($sformatf("v%0d_fail", i),  32'(fl),  32'(vecs[i].fail));
        end

        // Backpressure: result held for 3 cycles, second request waits
        ImmSrc = 2'b00; ImmVal = 32'h5A; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        ImmVal = 32'h33;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid),  32'd1);
            chk($sformatf("bp_hold%0d_field", c), 32'(InstrField), 32'h5A);
            chk($sformatf("bp_hold%0d_fail", c),  32'(Fail),       32'd0);
            chk($sformatf("bp_hold%0d_ready", c), 32'(in_ready),   32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_after_out_valid", 32'(out_valid), 32'd0);
        chk("bp_after_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_valid", 32'(out_valid),  32'd1);
        chk("bp_second_field", 32'(InstrField), 32'h33);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during SEARCH discards the search
        ImmSrc = 2'b11; ImmVal = 32'hFF00_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rs_searching_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_in_ready",  32'(in_ready),  32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("rs_no_stale_result", 32'(out_valid), 32'd0);
        send(2'b00, 32'h11, lat, fld, fl);
        chk("rs_next_lat",   32'(lat), 32'd1);
        chk("rs_next_field", 32'(fld), 32'h11);
        chk("rs_next_fail",  32'(fl),  32'd0);

        // Random sweep, modes 00..10
        for (int n = 0; n < 10000; n++) begin
            logic [1:0]  src;
            logic [31:0] r, v;
            logic [23:0] cand;
            logic        rep, ok;
            src = 2'($urandom_range(0, 2));
            r   = $urandom;
            v   = r;
            if ($urandom_range(0, 1) == 1) begin
                case (src)
                    2'b00:   v = r & 32'h0000_00FF;
                    2'b01:   v = r & 32'h0000_0FFF;
                    default: v = {{6{r[25]}}, r[25:2], 2'b00};
                endcase
                if ($urandom_range(0, 3) == 0) v = v ^ (32'd1 << $urandom_range(0, 31));
            end
            case (src)
                2'b00:   cand = {16'd0, v[7:0]};
                2'b01:   cand = {12'd0, v[11:0]};
                default: cand = v[25:2];
            endcase
            rep = (extend(cand, src) == v);
            send(src, v, lat, fld, fl);
            if (rep) ok = !fl && (fld == cand) && (extend(fld, src) == v);
            else     ok = fl && (fld == 24'd0);
            ok = ok && (lat == 1);
            chk($sformatf("rand_m%0d_%08h", src, v), 32'(ok), 32'd1);
        end

        // Random sweep, mode 11
        for (int n = 0; n < 500; n++) begin
            logic [31:0] v, t;
            logic        ok, any;
            int          rot;
            if ($urandom_range(0, 2) != 0)
                v = ror32({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
            else
                v = $urandom;
            send(2'b11, v, lat, fld, fl);
            if (!fl) begin
                rot = int'(fld[11:8]);
                ok  = (fld[23:12] == 12'd0) && (ror32({24'd0, fld[7:0]}, 2 * rot) == v);
                for (int k = 0; k < rot; k++) begin
                    t = rotl32(v, 2 * k);
                    if (t[31:8] == 24'd0) ok = 1'b0;
                end
                ok = ok && (lat == rot + 2);
            end else begin
                any = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    t = rotl32(v, 2 * k);
                    if (t[31:8] == 24'd0) any = 1'b1;
                end
                ok = !any && (fld == 24'd0) && (lat == 17);
            end
            chk($sformatf("rand_m3_%08h", v), 32'(ok), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Inverse of the datapath immediate extender. Takes a 32-bit constant and an ImmSrc code, and produces the 24-bit instruction-field bits that the extender expands back to that constant. Raises Fail if the constant cannot be represented.
- Used by the on-chip program loader/test-program builder, upstream of instruction memory.
- Adds ImmSrc=2'b11: the ARM rotated-immediate form, computed by an iterative rotation search.

Parameters:
- ROTS_PER_CYCLE, 1, rotation candidates tested per SEARCH cycle. Legal values 1, 2, 4, 8, 16.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- ImmVal  input  32  constant to encode.
- ImmSrc  input  2  00 imm8 zero-ext, 01 imm12 zero-ext, 10 branch signed word offset, 11 rotated imm8.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- InstrField  output  24  encoded field. Zero when Fail=1.
- Fail  output  1  constant not representable in the requested form.

Behaviour:
- Reset values: in_ready=1, out_valid=0, InstrField=0, Fail=0, state=IDLE. Reset mid-search or while holding a result discards all work; the next cycle is IDLE.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - A handshake occurs on a cycle with in_valid & in_ready; ImmVal and ImmSrc are registered.
  - ImmSrc 00/01/10: result computed combinationally from the inputs, registered, and the FSM goes to DONE. out_valid=1 on the next cycle.
  - ImmSrc 11: FSM goes to SEARCH with rot=0.
- Mode 00: encodable iff ImmVal[31:8]==0. InstrField={16'b0, ImmVal[7:0]}.
- Mode 01: encodable iff ImmVal[31:12]==0. InstrField={12'b0, ImmVal[11:0]}.
- Mode 10:
  - Encodable iff ImmVal[1:0]==0 and ImmVal[31:25] are all equal.
  - InstrField=ImmVal[25:2].
- Mode 11:
  - Find the smallest rot in 0..15 such that rotl(ImmVal, 2*rot)[31:8]==0.
  - InstrField={12'b0, rot[3:0], rotl(ImmVal, 2*rot)[7:0]}. Decoding this gives ror(imm8, 2*rot)==ImmVal.
- SEARCH:
  - Each cycle tests ROTS_PER_CYCLE consecutive rot values; the lowest hit wins.
  - On a hit, go to DONE with Fail=0.
  - If rot 15 is tested without a hit, go to DONE with Fail=1.
- Latency, counted from the handshake cycle to the cycle where out_valid rises: modes 00–10 take 1 cycle; mode 11 takes floor(k/ROTS_PER_CYCLE)+2 cycles for a hit at rot k, and 16/ROTS_PER_CYCLE+1 cycles on fail.
- DONE:
  - out_valid=1, in_ready=0.
  - InstrField and Fail are held stable until out_valid & out_ready, then the FSM returns to IDLE.
  - No same-cycle accept of a new request.
  - in_ready=0 in SEARCH and DONE.
- Round-trip invariant: for modes 00/01/10 with Fail=0, extend(InstrField, ImmSrc)==ImmVal.
- The encoder never emits an X value. Every ImmSrc value is defined.
- An in_valid that drops before handshake is ignored; there are no side effects.

Decomposition:
- Shared package imm_pkg holds:
  - typedef enum logic [1:0] imm_src_t {IMM8, IMM12, BRANCH, ROT8}. The extender uses this same encoding.
  - The FSM state enum.
  - Constant ROT_CANDIDATES=16.
- One sub-module, rot_check: combinational; takes value and rot; outputs hit and imm8. It is instantiated ROTS_PER_CYCLE times inside the SEARCH datapath.

Test Plan:
- Mode 00, ImmVal=0x000000A5 -> out_valid 1 cycle after handshake, InstrField=0x0000A5, Fail=0. Mode 01, ImmVal=0x00001000 -> Fail=1, InstrField=0.
- Mode 10, ImmVal=0xFFFFFFF8 -> InstrField=0xFFFFFE, Fail=0. Mode 10, ImmVal=0x00000006 -> Fail=1 (low bits nonzero). Mode 10, ImmVal=0x04000000 -> Fail=1 (out of range).
- Mode 11 with ROTS_PER_CYCLE=1:
  - ImmVal=0xFF000000 -> InstrField=0x0004FF, out_valid 6 cycles after handshake.
  - ImmVal=0x00000000 -> InstrField=0, 2 cycles.
  - ImmVal=0x00000102 -> Fail=1, 17 cycles.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> InstrField and Fail stable, in_ready=0, a second request is not accepted until the cycle after the out handshake.
- Assert reset for 1 cycle during SEARCH (mode 11, ImmVal=0xFF000000) -> next cycle out_valid=0, in_ready=1. A subsequent mode 00 request encodes normally.
- Random sweep of 10k values across modes 00–10: check the round-trip invariant against a reference model of the extender whenever Fail=0. Mode 11: check ror(imm8, 2*rot)==ImmVal and that rot is minimal.
